hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port id_instr, input, 16, the instruction in the ID stage.
REQ-004 SHALL have port id_valid, input, 1, meaning id_instr is a real instruction.
REQ-005 SHALL have port wb_valid, input, 1, pulsed when an instruction retires from WB.
REQ-006 SHALL have port wb_en, input, 1, meaning the retiring instruction writes the register file.
REQ-007 SHALL have port wb_dest, input, 4, the retiring destination register.
REQ-008 SHALL have port load_done, input, 1, pulsed when memory returns the outstanding load's data.
REQ-009 SHALL have port flush, input, 1, which squashes all in-flight instructions.
REQ-010 SHALL have port stall, output, 1, which holds ID and inserts a bubble into EX.
REQ-011 SHALL have port issue, output, 1, equal to id_valid AND NOT stall.
REQ-012 SHALL have port pend_mask, output, 16, where bit r is 1 when register r has a write in flight; bit 0 is always 0.
REQ-013 SHALL have port inflight, output, 2, the count of issued instructions not yet retired (0..3).
REQ-014 SHALL have port load_timeout, output, 1, a sticky load watchdog error.

Function
REQ-015 SHALL decode rs1 = id_instr[11:8] when opcode [15:12] != 0xE, else r0.
REQ-016 SHALL decode rs2 = [7:4] when opcode < 0x6, = [3:0] when [15:13] = 3'b110, else r0.
REQ-017 SHALL decode dest = [3:0] when [15:13] != 3'b110, else r0; opcode 0xB is a load.
REQ-018 SHALL keep a 2-bit writer counter per register r1..r15, incremented on issue with dest = r and decremented on wb_valid&wb_en with wb_dest = r.
REQ-019 SHALL leave a counter unchanged when the increment and the decrement occur in the same cycle.
REQ-020 SHALL never change a counter on dest or wb_dest = r0.
REQ-021 SHALL drive pend_mask[r] as (counter[r] != 0), from registered state.
REQ-022 SHALL update inflight as inflight + issue - wb_valid each cycle.
REQ-023 SHALL implement an FSM with states IDLE and LOAD_WAIT.
REQ-024 SHALL move IDLE -> LOAD_WAIT on issue of a load, capturing ld_dest = dest (r0 allowed) and clearing the wait counter.
REQ-025 SHALL move LOAD_WAIT -> IDLE on load_done.
REQ-026 SHALL ignore load_done received in IDLE.
REQ-027 SHALL, in LOAD_WAIT, increment a 4-bit wait counter each cycle, saturating at 15.
REQ-028 SHALL set load_timeout when the wait counter is at 15 with no load_done; it clears only on rst.
REQ-029 SHALL assert stall, using registered state only, when id_valid and any of these hold: (a) LOAD_WAIT and ld_dest != r0 and (rs1 = ld_dest or rs2 = ld_dest); (b) LOAD_WAIT and id_instr is a load; (c) LOAD_WAIT and dest = ld_dest != r0 (WAW); (d) inflight = 3 and wb_valid = 0.
REQ-030 SHALL not stall for non-load RAW hazards, which forwarding covers.
REQ-031 SHALL deassert stall the cycle after load_done, not in the same cycle.
REQ-032 SHALL hold stall low when id_valid = 0.
REQ-033 SHALL, on flush, clear all counters, set inflight = 0, enter IDLE and clear the wait counter next cycle; load_timeout is kept.
REQ-034 SHALL give flush priority over issue, wb_valid and load_done in the same cycle.
REQ-035 SHALL suppress issue in a cycle where flush is asserted.
REQ-036 SHALL give wb_valid with inflight = 0 no effect; inflight SHALL never underflow.

Reset
REQ-037 SHALL, on rst at a clock edge, clear all counters, set inflight = 0, state = IDLE, wait counter = 0 and load_timeout = 0.
REQ-038 SHALL give rst priority over flush and all other inputs.
REQ-039 SHALL hold pend_mask = 0 and stall = 0 in the cycle after reset.

Verification
REQ-040 SHALL cover load 0xB with dest r5, followed by ADD with rs1 = r5 -> stall = 1 in LOAD_WAIT; load_done at cycle N -> stall = 0 at N+1, issue = 1.
REQ-041 SHALL cover ALU writing r3, followed by a reader of r3 -> no stall; pend_mask[3] = 1 until the r3 WB retire.
REQ-042 SHALL cover back-to-back writers to r7, then a retire of the first -> pend_mask[7] stays 1; the second retire -> 0.
REQ-043 SHALL cover 3 issued, 0 retired, with a 4th instruction valid -> stall = 1; wb_valid pulse in the same cycle -> stall = 0 and inflight stays 3.
REQ-044 SHALL cover a load issued with load_done withheld 16 cycles -> load_timeout = 1 and sticky; flush -> state IDLE, load_timeout still 1.
REQ-045 SHALL cover issue with dest r2 and WB of r2 in the same cycle from counter = 1 -> counter stays 1; rst mid-LOAD_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a short in-order pipeline.
// Tracks in-flight register writers, the single outstanding load and the
// in-flight instruction count, and raises stall for load-use, load-after-load,
// load WAW and pipeline-full conditions. Plain ALU RAW hazards are left to
// the forwarding network.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] id_instr,
    input  logic        id_valid,
    input  logic        wb_valid,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic        load_done,
    input  logic        flush,
    output logic        stall,
    output logic        issue,
    output logic [15:0] pend_mask,
    output logic [1:0]  inflight,
    output logic        load_timeout
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'hB;
    localparam logic [3:0] OP_NORS1 = 4'hE;
    localparam logic [3:0] WAIT_MAX = 4'hF;

    state_t      state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [3:0]  ld_dest_reg, ld_dest_next;
    logic        load_timeout_reg, load_timeout_next;
    logic [1:0]  inflight_reg, inflight_next;

    logic [3:0]  opcode;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  dest;
    logic        is_load;
    logic        wb_write;
    logic        retire;

    // Instruction field decode; unused source/dest fields collapse to r0
    always_comb begin
        opcode  = id_instr[15:12];
        rs1     = 4'd0;
        rs2     = 4'd0;
        dest    = 4'd0;
        is_load = (opcode == OP_LOAD);
        if (opcode != OP_NORS1) begin
            rs1 = id_instr[11:8];
        end
        if (opcode < 4'h6) begin
            rs2 = id_instr[7:4];
        end else if (id_instr[15:13] == 3'b110) begin
            rs2 = id_instr[3:0];
        end
        if (id_instr[15:13] != 3'b110) begin
            dest = id_instr[3:0];
        end
    end

    // Stall decision from registered state plus the current ID/WB inputs
    always_comb begin
        logic in_load_wait;
        logic raw_hz;
        logic ld_hz;
        logic waw_hz;
        logic full_hz;
        in_load_wait = (state_reg == LOAD_WAIT);
        raw_hz  = in_load_wait && (ld_dest_reg != 4'd0) &&
                  ((rs1 == ld_dest_reg) || (rs2 == ld_dest_reg));
        ld_hz   = in_load_wait && is_load;
        waw_hz  = in_load_wait && (ld_dest_reg != 4'd0) && (dest == ld_dest_reg);
        full_hz = (inflight_reg == 2'd3) && !wb_valid;
        stall   = id_valid && (raw_hz || ld_hz || waw_hz || full_hz);
        issue   = id_valid && !stall && !flush;
    end

    assign wb_write = wb_valid && wb_en;
    // A retire pulse with nothing in flight is ignored so the count cannot wrap
    assign retire   = wb_valid && (inflight_reg != 2'd0);

    // Per-register writer counters for r1..r15; r0 is never tracked
    assign pend_mask[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < 16; gi++) begin : g_writer
            logic [1:0] cnt_reg, cnt_next;
            logic       inc;
            logic       dec;

            // Increment on issue, decrement on writeback, cancel when both
            always_comb begin
                inc      = issue && (dest == 4'(gi));
                dec      = wb_write && (wb_dest == 4'(gi));
                cnt_next = cnt_reg;
                if (flush) begin
                    cnt_next = 2'd0;
                end else if (inc && !dec && (cnt_reg != 2'd3)) begin
                    cnt_next = cnt_reg + 2'd1;
                end else if (dec && !inc && (cnt_reg != 2'd0)) begin
                    cnt_next = cnt_reg - 2'd1;
                end
            end

            // Counter register
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= 2'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign pend_mask[gi] = (cnt_reg != 2'd0);
        end
    endgenerate

    // In-flight count: plus one per issue, minus one per retire
    always_comb begin
        if (flush) begin
            inflight_next = 2'd0;
        end else begin
            inflight_next = inflight_reg + {1'b0, issue} - {1'b0, retire};
        end
    end

    // Load FSM next state, wait counter and sticky watchdog
    always_comb begin
        state_next        = state_reg;
        wait_cnt_next     = wait_cnt_reg;
        ld_dest_next      = ld_dest_reg;
        load_timeout_next = load_timeout_reg;
        if ((state_reg == LOAD_WAIT) && (wait_cnt_reg == WAIT_MAX) && !load_done) begin
            load_timeout_next = 1'b1;
        end
        if (flush) begin
            state_next    = IDLE;
            wait_cnt_next = 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue && is_load) begin
                        state_next    = LOAD_WAIT;
                        ld_dest_next  = dest;
                        wait_cnt_next = 4'd0;
                    end
                end
                LOAD_WAIT: begin
                    if (load_done) begin
                        state_next = IDLE;
                    end else if (wait_cnt_reg != WAIT_MAX) begin
                        wait_cnt_next = wait_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Shared state registers; reset overrides flush and everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            wait_cnt_reg     <= 4'd0;
            ld_dest_reg      <= 4'd0;
            load_timeout_reg <= 1'b0;
            inflight_reg     <= 2'd0;
        end else begin
            state_reg        <= state_next;
            wait_cnt_reg     <= wait_cnt_next;
            ld_dest_reg      <= ld_dest_next;
            load_timeout_reg <= load_timeout_next;
            inflight_reg     <= inflight_next;
        end
    end

    assign inflight     = inflight_reg;
    assign load_timeout = load_timeout_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: hand-computed vectors, one line per check.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic [15:0] id_instr;
    logic        id_valid;
    logic        wb_valid;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic        load_done;
    logic        flush;
    logic        stall;
    logic        issue;
    logic [15:0] pend_mask;
    logic [1:0]  inflight;
    logic        load_timeout;

    int vectors;
    int miscompares;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .wb_valid     (wb_valid),
        .wb_en        (wb_en),
        .wb_dest      (wb_dest),
        .load_done    (load_done),
        .flush        (flush),
        .stall        (stall),
        .issue        (issue),
        .pend_mask    (pend_mask),
        .inflight     (inflight),
        .load_timeout (load_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) begin
            $display("check %-14s observed=%0h expected=%0h ok", tag, obs, exp);
        end else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rising edge, then step 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        id_valid  = 1'b0;
        id_instr  = 16'h0000;
        wb_valid  = 1'b0;
        wb_en     = 1'b0;
        wb_dest   = 4'd0;
        load_done = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wb(input logic [3:0] r);
        wb_valid = 1'b1;
        wb_en    = 1'b1;
        wb_dest  = r;
    endtask

    task automatic present(input logic [15:0] ins);
        id_valid = 1'b1;
        id_instr = ins;
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_pend", 32'(pend_mask), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_timeout", 32'(load_timeout), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_issue", 32'(issue), 32'h0);

        // Load r5 then a reader of r5
        present(16'hB105);
        chk("ld_issue", 32'(issue), 32'h1);
        tick();
        chk("ld_pend", 32'(pend_mask), 32'h0020);
        chk("ld_inflight", 32'(inflight), 32'h1);
        present(16'h0526);
        chk("lu_stall", 32'(stall), 32'h1);
        chk("lu_issue", 32'(issue), 32'h0);
        tick();
        chk("lu_stall2", 32'(stall), 32'h1);
        chk("lu_inflight", 32'(inflight), 32'h1);
        present(16'hC095);
        chk("lu_rs2_store", 32'(stall), 32'h1);
        present(16'hB208);
        chk("ld_after_ld", 32'(stall), 32'h1);
        present(16'hE005);
        chk("waw_stall", 32'(stall), 32'h1);
        present(16'h1126);
        chk("no_hz_stall", 32'(stall), 32'h0);
        present(16'h0526);
        load_done = 1'b1;
        #1;
        chk("done_same_cyc", 32'(stall), 32'h1);
        tick();
        load_done = 1'b0;
        #1;
        chk("done_next_stl", 32'(stall), 32'h0);
        chk("done_next_iss", 32'(issue), 32'h1);
        tick();
        quiet();
        chk("add_pend", 32'(pend_mask), 32'h0060);
        chk("add_inflight", 32'(inflight), 32'h2);
        wb(4'd5);
        tick();
        chk("ret5_pend", 32'(pend_mask), 32'h0040);
        chk("ret5_inflight", 32'(inflight), 32'h1);
        wb(4'd6);
        tick();
        chk("ret6_pend", 32'(pend_mask), 32'h0000);
        chk("ret6_inflight", 32'(inflight), 32'h0);
        wb_valid = 1'b1;
        wb_en    = 1'b0;
        tick();
        chk("no_underflow", 32'(inflight), 32'h0);
        quiet();

        // ALU writer of r3 then a reader: forwarding covers it
        present(16'h1123);
        tick();
        chk("alu_pend", 32'(pend_mask), 32'h0008);
        present(16'h2314);
        chk("alu_raw_stall", 32'(stall), 32'h0);
        chk("alu_raw_issue", 32'(issue), 32'h1);
        tick();
        quiet();
        chk("alu2_pend", 32'(pend_mask), 32'h0018);
        wb(4'd3);
        tick();
        chk("ret3_pend", 32'(pend_mask), 32'h0010);
        wb(4'd4);
        tick();
        quiet();
        chk("ret4_pend", 32'(pend_mask), 32'h0000);

        // Two writers to r7
        present(16'h1127);
        tick();
        present(16'h2217);
        tick();
        quiet();
        chk("r7x2_pend", 32'(pend_mask), 32'h0080);
        chk("r7x2_inflight", 32'(inflight), 32'h2);
        wb(4'd7);
        tick();
        chk("r7_ret1_pend", 32'(pend_mask), 32'h0080);
        wb(4'd7);
        tick();
        quiet();
        chk("r7_ret2_pend", 32'(pend_mask), 32'h0000);
        chk("r7_inflight", 32'(inflight), 32'h0);

        // Pipeline full
        present(16'h1121);
        tick();
        present(16'h1122);
        tick();
        present(16'h1123);
        tick();
        quiet();
        chk("full_inflight", 32'(inflight), 32'h3);
        chk("full_pend", 32'(pend_mask), 32'h000E);
        present(16'h1124);
        chk("full_stall", 32'(stall), 32'h1);
        wb(4'd1);
        #1;
        chk("full_wb_stall", 32'(stall), 32'h0);
        chk("full_wb_issue", 32'(issue), 32'h1);
        tick();
        quiet();
        chk("full_keep3", 32'(inflight), 32'h3);
        chk("full_pend2", 32'(pend_mask), 32'h001C);
        flush = 1'b1;
        present(16'h1125);
        chk("flush_no_iss", 32'(issue), 32'h0);
        tick();
        quiet();
        chk("flush_pend", 32'(pend_mask), 32'h0000);
        chk("flush_inflight", 32'(inflight), 32'h0);

        // Simultaneous issue and writeback of r2 with counter at 1
        present(16'h1122);
        tick();
        present(16'h1132);
        wb(4'd2);
        tick();
        quiet();
        chk("same_cyc_pend", 32'(pend_mask), 32'h0004);
        chk("same_cyc_infl", 32'(inflight), 32'h1);
        wb(4'd2);
        tick();
        quiet();
        chk("r2_final_pend", 32'(pend_mask), 32'h0000);
        chk("r2_final_infl", 32'(inflight), 32'h0);

        // Load watchdog
        present(16'hB10A);
        tick();
        quiet();
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("wd_at_15", 32'(load_timeout), 32'h0);
        tick();
        chk("wd_at_16", 32'(load_timeout), 32'h1);
        tick();
        tick();
        chk("wd_sticky", 32'(load_timeout), 32'h1);
        flush = 1'b1;
        tick();
        quiet();
        chk("wd_flush_keep", 32'(load_timeout), 32'h1);
        chk("wd_flush_pend", 32'(pend_mask), 32'h0000);
        chk("wd_flush_infl", 32'(inflight), 32'h0);
        present(16'h1A11);
        chk("idle_rd_r10", 32'(stall), 32'h0);
        present(16'hB203);
        chk("idle_load", 32'(stall), 32'h0);
        quiet();

        // Reset in the middle of a load wait
        present(16'hB105);
        tick();
        chk("ld2_pend", 32'(pend_mask), 32'h0020);
        present(16'h0526);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        quiet();
        #1;
        chk("rst_lw_pend", 32'(pend_mask), 32'h0);
        chk("rst_lw_infl", 32'(inflight), 32'h0);
        chk("rst_lw_timeout", 32'(load_timeout), 32'h0);
        chk("rst_lw_stall", 32'(stall), 32'h0);
        chk("rst_lw_issue", 32'(issue), 32'h0);
        present(16'h0526);
        chk("rst_lw_idle", 32'(stall), 32'h0);
        quiet();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
